csr_tohost_reporter: RTL and testbench

- Listener at the far end of the EX-stage CSR write path. It snoops CSR writes and captures every write to the tohost CSR into a small FIFO.
- It then drains each captured 32-bit word as four bytes, little-endian, over a valid/ready byte stream that feeds the UART transmitter.
- The host sees program status/exit codes without stalling the core. The block never back-pressures the pipeline.

---
 rtl/csr_tohost_reporter_pkg.sv | 17 +
 rtl/csr_tohost_reporter_if.sv | 21 ++
 rtl/csr_tohost_reporter_fifo.sv | 48 ++++
 rtl/csr_tohost_reporter.sv | 125 ++++++++++++
 tb/tb_csr_tohost_reporter.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/csr_tohost_reporter_pkg.sv
// Shared definitions for the tohost reporter: the captured CSR address,
// FSM state encoding and a small sizing helper.
package csr_tohost_reporter_pkg;

  localparam logic [11:0] CSR_TOHOST_ADDR = 12'h51E;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Byte-index width; never zero so an 8-bit CSR still gets a legal vector.
  function automatic int idx_width(input int nbytes);
    return (nbytes > 1) ? $clog2(nbytes) : 1;
  endfunction

endpackage

// File: rtl/csr_tohost_reporter_if.sv
// CSR write snoop bus plus the valid/ready byte stream towards the UART TX.
interface csr_tohost_reporter_if #(
  parameter int DWIDTH = 32
);
  logic              csr_we;
  logic [11:0]       csr_addr;
  logic [DWIDTH-1:0] csr_wdata;
  logic [7:0]        byte_out;
  logic              byte_out_valid;
  logic              byte_out_ready;

  modport master (
    output csr_we, csr_addr, csr_wdata, byte_out_ready,
    input  byte_out, byte_out_valid
  );

  modport slave (
    input  csr_we, csr_addr, csr_wdata, byte_out_ready,
    output byte_out, byte_out_valid
  );
endinterface

// File: rtl/csr_tohost_reporter_fifo.sv
// Synchronous first-word-fall-through FIFO holding captured tohost words.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module csr_report_fifo #(
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [DWIDTH-1:0]      din,
  output logic [DWIDTH-1:0]      dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (count == (AW+1)'(DEPTH));
  assign dout  = mem[rd_ptr[AW-1:0]];

  // A push into a full FIFO is legal when the head leaves at the same edge.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/csr_tohost_reporter.sv
// Snoops EX-stage CSR writes, queues tohost values and streams each word
// little-endian as bytes to the UART TX without ever stalling the core.
//
//   state | meaning
//   IDLE  | nothing in flight; load the FIFO head when one is queued
//   SEND  | byte_out/byte_out_valid present sh[byte_idx] until accepted
module csr_tohost_reporter
  import csr_tohost_reporter_pkg::*;
#(
  parameter int          DWIDTH   = 32,
  parameter int          DEPTH    = 4,
  parameter logic [11:0] CSR_ADDR = CSR_TOHOST_ADDR
) (
  input  logic                      clk,
  input  logic                      rst,
  csr_tohost_reporter_if.slave      bus,
  input  logic                      clear_overflow,
  output logic [$clog2(DEPTH):0]    fifo_count,
  output logic                      busy,
  output logic                      overflow
);
  localparam int          NB   = DWIDTH / 8;
  localparam int          IW   = idx_width(NB);
  localparam logic [IW-1:0] LAST = IW'(NB - 1);

  state_t            state_q, state_d;
  logic [DWIDTH-1:0] sh_q, sh_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [7:0]        byte_q, byte_d;
  logic              valid_q, valid_d;

  logic              capture;
  logic              pop;
  logic              push;
  logic              drop;
  logic              full;
  logic              empty;
  logic [DWIDTH-1:0] head;

  assign capture = bus.csr_we && (bus.csr_addr == CSR_ADDR);
  assign push    = capture && (!full || pop);
  assign drop    = capture && full && !pop;

  csr_report_fifo #(
    .DWIDTH (DWIDTH),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (bus.csr_wdata),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      idx_q   <= '0;
      byte_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      idx_q   <= idx_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    idx_d   = idx_q;
    byte_d  = byte_q;
    valid_d = valid_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          sh_d    = head;
          idx_d   = '0;
          byte_d  = head[7:0];
          valid_d = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (valid_q && bus.byte_out_ready) begin
          if (idx_q != LAST) begin
            idx_d  = idx_q + 1'b1;
            byte_d = sh_q[{idx_q + 1'b1, 3'b000} +: 8];
          end else if (!empty) begin
            // Chain straight into the next word so the stream has no bubble.
            pop    = 1'b1;
            sh_d   = head;
            idx_d  = '0;
            byte_d = head[7:0];
          end else begin
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A drop at the same edge as a clear must stay visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 overflow <= 1'b0;
    else if (drop)           overflow <= 1'b1;
    else if (clear_overflow) overflow <= 1'b0;
  end

  assign bus.byte_out       = byte_q;
  assign bus.byte_out_valid = valid_q;
  assign busy               = (state_q == SEND);

endmodule

// File: tb/tb_csr_tohost_reporter.sv
// Scoreboarded bench for csr_tohost_reporter: a word-level queue model
// predicts the byte stream and status; a negedge monitor compares.
module tb_csr_tohost_reporter;
  import csr_tohost_reporter_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int NB    = DW / 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clear_overflow = 1'b0;
  logic [2:0] fifo_count;
  logic       busy;
  logic       overflow;

  csr_tohost_reporter_if #(.DWIDTH(DW)) bus ();

  csr_tohost_reporter #(.DWIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .clear_overflow (clear_overflow),
    .fifo_count     (fifo_count),
    .busy           (busy),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queued words, bytes left of the word on the wire,
  // and the expected byte stream in acceptance order.
  logic [31:0] m_pend[$];
  logic [7:0]  m_exp[$];
  bit          m_send = 1'b0;
  int          m_left = 0;
  bit          m_ovf  = 1'b0;
  int          m_sz;
  bit          m_popped;
  bit          m_drop;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pend.delete();
      m_exp.delete();
      m_send = 1'b0;
      m_left = 0;
      m_ovf  = 1'b0;
    end else begin
      m_sz     = m_pend.size();
      m_popped = 1'b0;
      m_drop   = 1'b0;
      if (!m_send) begin
        if (m_sz > 0) begin
          void'(m_pend.pop_front());
          m_send = 1'b1; m_left = NB; m_popped = 1'b1;
        end
      end else if (bus.byte_out_ready) begin
        m_left--;
        if (m_left == 0) begin
          if (m_sz > 0) begin
            void'(m_pend.pop_front());
            m_left = NB; m_popped = 1'b1;
          end else begin
            m_send = 1'b0;
          end
        end
      end
      if (bus.csr_we && bus.csr_addr == CSR_TOHOST_ADDR) begin
        if (m_sz < DEPTH || m_popped) begin
          m_pend.push_back(bus.csr_wdata);
          for (int b = 0; b < NB; b++) m_exp.push_back(8'((bus.csr_wdata >> (8 * b)) & 32'hFF));
        end else begin
          m_drop = 1'b1;
          m_ovf  = 1'b1;
        end
      end
      if (clear_overflow && !m_drop) m_ovf = 1'b0;
    end
  end

  bit         hold_v = 1'b0;
  logic [7:0] hold_b = '0;
  int         n_bytes = 0;

  always @(negedge clk) begin
    chk("valid", bus.byte_out_valid, m_send);
    chk("busy", busy, m_send);
    chk("fifo_count", fifo_count, m_pend.size());
    chk("overflow", overflow, m_ovf);
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) chk("byte_stable", bus.byte_out, hold_b);
      if (bus.byte_out_valid && bus.byte_out_ready) begin
        n_bytes++;
        if (m_exp.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL byte_unexpected: got %0h expected none at %0t", bus.byte_out, $time);
        end else begin
          chk("byte", bus.byte_out, m_exp.pop_front());
        end
      end
      hold_v = bus.byte_out_valid && !bus.byte_out_ready;
      hold_b = bus.byte_out;
    end
  end

  // Called at posedge+1: applies inputs for the coming edge, returns at next posedge+1.
  task automatic cyc(input bit we, input logic [11:0] a, input logic [31:0] d,
                     input bit rdy, input bit clr);
    bus.csr_we         = we;
    bus.csr_addr       = a;
    bus.csr_wdata      = d;
    bus.byte_out_ready = rdy;
    clear_overflow     = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cyc(1'b0, 12'h000, 32'h0, rdy, 1'b0);
  endtask

  logic [7:0] t1_bytes [4];
  logic [11:0] r_addr;

  initial begin
    t1_bytes[0] = 8'hEF; t1_bytes[1] = 8'hBE; t1_bytes[2] = 8'hAD; t1_bytes[3] = 8'hDE;
    bus.csr_we = 1'b0; bus.csr_addr = '0; bus.csr_wdata = '0; bus.byte_out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", bus.byte_out_valid, 1'b0);
    chk("rst_byte", bus.byte_out, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_count", fifo_count, 3'd0);
    chk("rst_overflow", overflow, 1'b0);
    rst = 1'b0;
    idle(2, 1'b1);

    // Single word, ready held high: one IDLE cycle, then four bytes.
    cyc(1'b1, 12'h51E, 32'hDEADBEEF, 1'b1, 1'b0);
    chk("t1_valid_early", bus.byte_out_valid, 1'b0);
    idle(1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("t1_valid", bus.byte_out_valid, 1'b1);
      chk("t1_byte", bus.byte_out, t1_bytes[i]);
      idle(1, 1'b1);
    end
    chk("t1_busy_end", busy, 1'b0);
    chk("t1_count_end", fifo_count, 3'd0);

    // Wrong address, and right address without the strobe.
    cyc(1'b1, 12'h51D, 32'h11111111, 1'b1, 1'b0);
    cyc(1'b0, 12'h51E, 32'h22222222, 1'b1, 1'b0);
    idle(3, 1'b1);
    chk("t2_valid", bus.byte_out_valid, 1'b0);
    chk("t2_count", fifo_count, 3'd0);

    // Six writes with the sink stalled: four queue, one in flight, one dropped.
    for (int w = 1; w <= 6; w++) cyc(1'b1, 12'h51E, 32'(w), 1'b0, 1'b0);
    chk("t3_count_full", fifo_count, 3'd4);
    chk("t3_overflow", overflow, 1'b1);
    idle(25, 1'b1);
    chk("t3_overflow_sticky", overflow, 1'b1);
    chk("t3_bytes", n_bytes, 32'd24);
    cyc(1'b0, 12'h000, 32'h0, 1'b1, 1'b1);
    chk("t3_overflow_clear", overflow, 1'b0);

    // Random back-pressure on a single word.
    cyc(1'b1, 12'h51E, 32'h12345678, ($urandom_range(0, 1) == 1), 1'b0);
    for (int i = 0; i < 30; i++) idle(1, ($urandom_range(0, 1) == 1));
    idle(6, 1'b1);
    chk("t4_idle", busy, 1'b0);

    // Full FIFO with a capture on the last-byte handshake edge.
    for (int w = 0; w < 5; w++) cyc(1'b1, 12'h51E, 32'hA0000001 + 32'(w), 1'b0, 1'b0);
    chk("t5_count_full", fifo_count, 3'd4);
    chk("t5_overflow_pre", overflow, 1'b0);
    idle(3, 1'b1);
    cyc(1'b1, 12'h51E, 32'hA0000006, 1'b1, 1'b0);
    chk("t5_overflow", overflow, 1'b0);
    chk("t5_count", fifo_count, 3'd4);
    idle(30, 1'b1);

    // Async reset in the middle of a word with two words queued.
    cyc(1'b1, 12'h51E, 32'hCAFEF00D, 1'b0, 1'b0);
    cyc(1'b1, 12'h51E, 32'h0BADC0DE, 1'b0, 1'b0);
    cyc(1'b1, 12'h51E, 32'h600DF00D, 1'b0, 1'b0);
    idle(2, 1'b1);
    idle(1, 1'b0);
    chk("t6_count_pre", fifo_count, 3'd2);
    chk("t6_byte_pre", bus.byte_out, 8'hFE);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_valid", bus.byte_out_valid, 1'b0);
    chk("t6_byte", bus.byte_out, 8'h00);
    chk("t6_busy", busy, 1'b0);
    chk("t6_count", fifo_count, 3'd0);
    chk("t6_overflow", overflow, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(10, 1'b1);
    chk("t6_quiet", bus.byte_out_valid, 1'b0);
    cyc(1'b1, 12'h51E, 32'hA5A55A5A, 1'b1, 1'b0);
    idle(8, 1'b1);

    // Random traffic: heavy back-pressure first, then a mostly-ready sink.
    for (int i = 0; i < 400; i++) begin
      r_addr = ($urandom_range(0, 3) == 0) ? 12'(12'h51E ^ (12'h001 << $urandom_range(0, 11))) : 12'h51E;
      cyc(($urandom_range(0, 2) != 0), r_addr, $urandom,
          (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 15) == 0));
    end
    idle(40, 1'b1);
    chk("drain_exp_empty", m_exp.size(), 32'd0);
    chk("drain_busy", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
